// File: rtl/exec_pkg.sv
// Shared encodings and constants for the execute-stage ALU/branch unit.
package exec_pkg;

    localparam int WIDTH = 32;
    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_BEQ    = 3'd1,
        BR_BNE    = 3'd2,
        BR_BLTZ   = 3'd3,
        BR_BGEZ   = 3'd4,
        BR_BLTZAL = 3'd5,
        BR_BGEZAL = 3'd6
    } br_op_e;

endpackage

// File: rtl/alu32.sv
// Purely combinational 32-bit MIPS ALU with signed overflow detection on ADD/SUB.
module alu32 #(
    parameter int WIDTH = exec_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    input  logic [3:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);
    import exec_pkg::*;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Select the operation; unused codes fall through to a zero result.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result = '0;
        ovf    = 1'b0;
        case (alu_op_e'(alu_op))
            ALU_ADD: begin
                result = sum;
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $signed(b) >>> shamt;
            ALU_LUI:  result = {b[15:0], 16'h0000};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/exec_branch_unit.sv
// Execute stage: ALU, branch condition/target, link logic and one output register stage.
module exec_branch_unit #(
    parameter int WIDTH = exec_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [15:0]      imm16,
    input  logic [4:0]       shamt,
    input  logic [3:0]       alu_op,
    input  logic [2:0]       br_op,
    input  logic [4:0]       rd_in,
    input  logic             rd_we,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             taken,
    output logic [WIDTH-1:0] target,
    output logic             wr_en,
    output logic [4:0]       wr_reg
);
    import exec_pkg::*;

    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic [WIDTH-1:0] link_addr;
    logic [WIDTH-1:0] target_c;
    logic [WIDTH-1:0] result_c;
    logic             ovf_c;
    logic             taken_c;
    logic             wr_en_c;
    logic [4:0]       wr_reg_c;

    alu32 #(.WIDTH(WIDTH)) u_alu (
        .a      (a),
        .b      (b),
        .shamt  (shamt),
        .alu_op (alu_op),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    // No delay slot, so the link address is simply the next sequential pc.
    assign link_addr = pc + WIDTH'(4);
    assign target_c  = link_addr + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};

    // Branch condition, link override and writeback selection.
    always_comb begin
        taken_c  = 1'b0;
        result_c = alu_result;
        ovf_c    = alu_ovf;
        wr_en_c  = 1'b0;
        wr_reg_c = 5'd0;
        case (br_op_e'(br_op))
            BR_BEQ:  taken_c = (a == b);
            BR_BNE:  taken_c = (a != b);
            BR_BLTZ: taken_c = a[WIDTH-1];
            BR_BGEZ: taken_c = ~a[WIDTH-1];
            BR_BLTZAL, BR_BGEZAL: begin
                // Link happens whether or not the branch is taken.
                taken_c  = (br_op_e'(br_op) == BR_BLTZAL) ? a[WIDTH-1] : ~a[WIDTH-1];
                result_c = link_addr;
                ovf_c    = 1'b0;
                wr_en_c  = 1'b1;
                wr_reg_c = LINK_REG;
            end
            default: begin
                // NONE and the reserved code behave as a plain ALU instruction.
                wr_en_c  = rd_we;
                wr_reg_c = rd_in;
            end
        endcase
    end

    // Output register stage; a bubble clears the control outputs only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            taken     <= 1'b0;
            target    <= '0;
            wr_en     <= 1'b0;
            wr_reg    <= 5'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            out_valid <= in_valid;
            result    <= result_c;
            zero      <= (result_c == '0);
            ovf       <= ovf_c;
            taken     <= in_valid & taken_c;
            target    <= target_c;
            wr_en     <= in_valid & wr_en_c;
            wr_reg    <= wr_reg_c;
        end
    end

endmodule

// File: tb/tb_exec_branch_unit.sv
// Self-checking bench for exec_branch_unit: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_exec_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm16;
    logic [4:0]  shamt;
    logic [3:0]  alu_op;
    logic [2:0]  br_op;
    logic [4:0]  rd_in;
    logic        rd_we;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        taken;
    logic [31:0] target;
    logic        wr_en;
    logic [4:0]  wr_reg;

    int n_vec;
    int n_miss;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic        taken;
        logic [31:0] target;
        logic        wr_en;
        logic [4:0]  wr_reg;
    } outs_t;

    exec_branch_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .pc        (pc),
        .a         (a),
        .b         (b),
        .imm16     (imm16),
        .shamt     (shamt),
        .alu_op    (alu_op),
        .br_op     (br_op),
        .rd_in     (rd_in),
        .rd_we     (rd_we),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .taken     (taken),
        .target    (target),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t observed();
        return '{out_valid, result, zero, ovf, taken, target, wr_en, wr_reg};
    endfunction

    // Reference behaviour computed straight from the instruction semantics.
    function automatic outs_t model();
        outs_t  e;
        longint sa, sb, wide;
        int     off;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (int'(alu_op))
            0:  begin wide = sa + sb; e.result = a + b; e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            1:  begin wide = sa - sb; e.result = a - b; e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            2:  e.result = a & b;
            3:  e.result = a | b;
            4:  e.result = a ^ b;
            5:  e.result = ~(a | b);
            6:  e.result = (sa < sb) ? 32'd1 : 32'd0;
            7:  e.result = (a < b) ? 32'd1 : 32'd0;
            8:  e.result = b << shamt;
            9:  e.result = b >> shamt;
            10: e.result = 32'(sb >>> shamt);
            11: e.result = b * 32'd65536;
            default: e.result = 32'd0;
        endcase
        off      = int'($signed(imm16)) * 4;
        e.target = pc + 32'd4 + 32'(off);
        case (int'(br_op))
            1: e.taken = (a == b);
            2: e.taken = (a != b);
            3: e.taken = (sa < 0);
            4: e.taken = (sa >= 0);
            5, 6: begin
                e.taken  = (br_op == 3'd5) ? (sa < 0) : (sa >= 0);
                e.result = pc + 32'd4;
                e.ovf    = 1'b0;
                e.wr_en  = 1'b1;
                e.wr_reg = 5'd31;
            end
            default: begin
                e.wr_en  = rd_we;
                e.wr_reg = rd_in;
            end
        endcase
        e.zero  = (e.result == 32'd0);
        e.valid = in_valid;
        if (!in_valid) begin
            e.taken = 1'b0;
            e.wr_en = 1'b0;
        end
        return e;
    endfunction

    task automatic set_op(input logic [31:0] pc_v, input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [15:0] imm_v, input logic [4:0] sh_v, input logic [3:0] alu_v,
                          input logic [2:0] br_v, input logic [4:0] rd_v, input logic we_v);
        in_valid = 1'b1;
        pc = pc_v; a = a_v; b = b_v; imm16 = imm_v; shamt = sh_v;
        alu_op = alu_v; br_op = br_v; rd_in = rd_v; rd_we = we_v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        set_op(32'h0, 32'h0, 32'h0, 16'h0, 5'd0, 4'd0, 3'd0, 5'd0, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        step();
        n_vec++;
        if (observed() !== outs_t'(0)) begin
            n_miss++;
            $display("FAIL reset_state: got %h want %h", observed(), outs_t'(0));
        end
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_add_overflow();
        set_op(32'h0, 32'h7FFF_FFFF, 32'h1, 16'h0, 5'd0, 4'd0, 3'd0, 5'd5, 1'b1);
        step();
        n_vec++;
        if ({out_valid, result, ovf, wr_en, wr_reg} !== {1'b1, 32'h8000_0000, 1'b1, 1'b1, 5'd5}) begin
            n_miss++;
            $display("FAIL add_overflow: got v=%b res=%h ovf=%b we=%b reg=%0d want v=1 res=80000000 ovf=1 we=1 reg=5",
                     out_valid, result, ovf, wr_en, wr_reg);
        end
    endtask

    task automatic test_slt_sltu();
        set_op(32'h0, 32'hFFFF_FFFF, 32'h1, 16'h0, 5'd0, 4'd6, 3'd0, 5'd2, 1'b1);
        step();
        n_vec++;
        if ({result, zero} !== {32'h1, 1'b0}) begin
            n_miss++;
            $display("FAIL slt_signed: got res=%h zero=%b want res=00000001 zero=0", result, zero);
        end
        alu_op = 4'd7;
        step();
        n_vec++;
        if ({result, zero} !== {32'h0, 1'b1}) begin
            n_miss++;
            $display("FAIL sltu_unsigned: got res=%h zero=%b want res=00000000 zero=1", result, zero);
        end
    endtask

    task automatic test_beq_backward();
        set_op(32'h0000_3010, 32'd7, 32'd7, 16'hFFFC, 5'd0, 4'd0, 3'd1, 5'd9, 1'b1);
        step();
        n_vec++;
        if ({taken, target, wr_en} !== {1'b1, 32'h0000_3004, 1'b0}) begin
            n_miss++;
            $display("FAIL beq_backward: got tk=%b tgt=%h we=%b want tk=1 tgt=00003004 we=0", taken, target, wr_en);
        end
    endtask

    task automatic test_bltzal();
        set_op(32'h0000_3000, 32'h8000_0000, 32'h0, 16'h0003, 5'd0, 4'd0, 3'd5, 5'd4, 1'b0);
        step();
        n_vec++;
        if ({taken, target, result, wr_en, wr_reg} !== {1'b1, 32'h0000_3010, 32'h0000_3004, 1'b1, 5'd31}) begin
            n_miss++;
            $display("FAIL bltzal_taken: got tk=%b tgt=%h res=%h we=%b reg=%0d want tk=1 tgt=00003010 res=00003004 we=1 reg=31",
                     taken, target, result, wr_en, wr_reg);
        end
        a = 32'd5;
        step();
        n_vec++;
        if ({taken, result, wr_en, wr_reg} !== {1'b0, 32'h0000_3004, 1'b1, 5'd31}) begin
            n_miss++;
            $display("FAIL bltzal_not_taken: got tk=%b res=%h we=%b reg=%0d want tk=0 res=00003004 we=1 reg=31",
                     taken, result, wr_en, wr_reg);
        end
    endtask

    task automatic test_reset_mid_stream();
        set_op(32'h0000_3000, 32'h8000_0000, 32'h0, 16'h0003, 5'd0, 4'd0, 3'd5, 5'd4, 1'b0);
        step();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (observed() !== outs_t'(0)) begin
            n_miss++;
            $display("FAIL reset_async_clear: got %h want %h", observed(), outs_t'(0));
        end
        step();
        n_vec++;
        if (observed() !== outs_t'(0)) begin
            n_miss++;
            $display("FAIL reset_held_over_edge: got %h want %h", observed(), outs_t'(0));
        end
        #3 rst_n = 1'b1;
        set_op(32'h0, 32'h0, 32'h8000_0000, 16'h0, 5'd4, 4'd10, 3'd0, 5'd7, 1'b1);
        step();
        n_vec++;
        if ({out_valid, result, wr_reg} !== {1'b1, 32'hF800_0000, 5'd7}) begin
            n_miss++;
            $display("FAIL sra_after_reset: got v=%b res=%h reg=%0d want v=1 res=f8000000 reg=7", out_valid, result, wr_reg);
        end
    endtask

    task automatic test_random_back_to_back();
        outs_t exp_o;
        outs_t got_o;
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 9) != 0);
            pc       = $urandom & 32'hFFFF_FFFC;
            a        = $urandom;
            b        = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h7FFF_FFFF;
            imm16    = 16'($urandom);
            shamt    = 5'($urandom);
            alu_op   = 4'($urandom);
            br_op    = 3'($urandom);
            rd_in    = 5'($urandom);
            rd_we    = 1'($urandom);
            exp_o    = model();
            step();
            got_o    = observed();
            if (!exp_o.valid) begin
                got_o = '{valid: got_o.valid, taken: got_o.taken, wr_en: got_o.wr_en, default: '0};
                exp_o = '{valid: exp_o.valid, taken: exp_o.taken, wr_en: exp_o.wr_en, default: '0};
            end
            n_vec++;
            if (got_o !== exp_o) begin
                n_miss++;
                $display("FAIL random[%0d] alu=%0d br=%0d: got %h want %h", i, alu_op, br_op, got_o, exp_o);
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        test_reset();
        test_add_overflow();
        test_slt_sltu();
        test_beq_backward();
        test_bltzal();
        test_reset_mid_stream();
        test_random_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
